// File: rtl/uart_pkg.sv
// Shared types and constants for the peak-word UART transmitter.
// Holds the serialiser state encoding and the frame layout helpers.
package uart_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    START = ST_START,
    DATA  = ST_DATA,
    STOP  = ST_STOP
  } state_t;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
  localparam int         FRAME_BYTES  = 5;

  // Byte idx of the 40-bit shadow, idx 0 being bits [39:32].
  function automatic logic [7:0] frame_byte(
    input logic [39:0] shadow,
    input logic [2:0]  idx
  );
    logic [39:0] s;
    s = shadow << {idx, 3'b000};
    return s[39:32];
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 single-byte serialiser, LSB first.
// ready marks a cycle in which load is taken; tx lags the state by one flop.
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] byte_in,
  output logic       tx,
  output logic       ready
);

  localparam logic [15:0] LAST = 16'(BAUD_DIV - 1);

  state_t      state;
  state_t      state_n;
  logic [15:0] baud;
  logic [15:0] baud_n;
  logic [2:0]  bit_idx;
  logic [2:0]  bit_n;
  logic [7:0]  data;
  logic [7:0]  data_n;
  logic        tick;
  logic        line;

  assign tick  = (baud == LAST);
  assign ready = (state == IDLE) ||
                 ((state == STOP) && tick);

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      data    <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_idx <= bit_n;
      data    <= data_n;
      tx      <= line;
    end
  end

  always_comb begin
    line = 1'b1;
    unique case (1'b1)
      (state == START): line = 1'b0;
      (state == DATA):  line = data[bit_idx];
      default:          line = 1'b1;
    endcase
  end

  // A load in the final stop cycle chains straight into the next start bit.
  always_comb begin
    state_n = state;
    baud_n  = tick ? '0 : baud + 16'd1;
    bit_n   = bit_idx;
    data_n  = data;
    unique case (state)
      IDLE: begin
        baud_n = '0;
        if (load) begin
          state_n = START;
          data_n  = byte_in;
        end
      end
      START: begin
        if (tick) begin
          state_n = DATA;
          bit_n   = '0;
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_idx == 3'd7) state_n = STOP;
          else                 bit_n   = bit_idx + 3'd1;
        end
      end
      STOP: begin
        if (tick) begin
          if (load) begin
            state_n = START;
            data_n  = byte_in;
          end else begin
            state_n = IDLE;
          end
        end
      end
    endcase
  end

endmodule

// File: rtl/peak_uart_tx.sv
// Frame sequencer: sends {SYNC_BYTE, data_in} as five gapless 8N1 bytes.
// busy spans the accept edge to the last stop cycle; done pulses once after.
module peak_uart_tx
  import uart_pkg::*;
#(
  parameter int         BAUD_DIV  = 434,
  parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        send,
  input  logic [31:0] data_in,
  output logic        busy,
  output logic        done,
  output logic        tx
);

  localparam logic [2:0] LAST_BYTE = 3'(FRAME_BYTES - 1);

  logic [39:0] shadow;
  logic [2:0]  byte_idx;
  logic        ready;
  logic        accept;
  logic        advance;
  logic        finish;
  logic        load;
  logic [7:0]  byte_in;

  assign accept  = send && !busy;
  assign advance = busy && ready && (byte_idx != LAST_BYTE);
  assign finish  = busy && ready && (byte_idx == LAST_BYTE);
  assign load    = accept || advance;

  // The sync byte goes straight in on accept; the shadow is not loaded yet.
  assign byte_in = accept ? SYNC_BYTE
                          : frame_byte(shadow, byte_idx + 3'd1);

  always_ff @(posedge clock) begin
    if (reset) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      byte_idx <= '0;
      shadow   <= '0;
    end else begin
      done <= finish;
      if (accept) begin
        busy     <= 1'b1;
        byte_idx <= '0;
        shadow   <= {SYNC_BYTE, data_in};
      end else if (advance) begin
        byte_idx <= byte_idx + 3'd1;
      end else if (finish) begin
        busy     <= 1'b0;
        byte_idx <= '0;
      end
    end
  end

  uart_tx_byte #(
    .BAUD_DIV(BAUD_DIV)
  ) u_byte (
    .clock  (clock),
    .reset  (reset),
    .load   (load),
    .byte_in(byte_in),
    .tx     (tx),
    .ready  (ready)
  );

endmodule

// File: tb/tb_peak_uart_tx.sv
// Bench for peak_uart_tx: per-cycle line/busy/done reference plus a
// mid-bit UART decoder compared against the accepted frame bytes.
module tb_peak_uart_tx;

  localparam int BAUD  = 4;
  localparam int FRAME = 50 * BAUD;

  logic        clock = 1'b0;
  logic        reset;
  logic        send;
  logic [31:0] data_in;
  logic        busy;
  logic        done;
  logic        tx;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  peak_uart_tx #(
    .BAUD_DIV (BAUD),
    .SYNC_BYTE(8'hA5)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .send   (send),
    .data_in(data_in),
    .busy   (busy),
    .done   (done),
    .tx     (tx)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: frame accepted at edge m_t0 owns the line for edges
  // m_t0+1 .. m_t0+FRAME, one bit per BAUD edges.
  int         n = 0;
  bit         m_on = 0;
  int         m_t0 = 0;
  logic [7:0] m_bytes [5];

  int         mon_start = -1;
  logic [7:0] mon_sh;
  logic       prev_tx = 1'b1;
  logic [7:0] rx_q [$];

  int done_cnt = 0;
  int busy_cnt = 0;

  function automatic logic exp_bit(input int k);
    int b;
    int p;
    b = k / 10;
    p = k % 10;
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return m_bytes[b][p-1];
  endfunction

  task automatic step();
    bit   was_busy;
    int   off;
    int   d;
    logic e_busy;
    logic e_done;
    logic e_tx;
    was_busy = m_on && (n - m_t0) < FRAME;
    @(posedge clock);
    n++;
    if (reset) begin
      m_on      = 0;
      mon_start = -1;
      rx_q.delete();
    end else if (send && !was_busy) begin
      m_on       = 1;
      m_t0       = n;
      m_bytes[0] = 8'hA5;
      m_bytes[1] = data_in[31:24];
      m_bytes[2] = data_in[23:16];
      m_bytes[3] = data_in[15:8];
      m_bytes[4] = data_in[7:0];
    end
    #1;
    off    = n - m_t0;
    e_busy = m_on && off < FRAME;
    e_done = m_on && off == FRAME;
    e_tx   = (m_on && off >= 1 && off <= FRAME)
             ? exp_bit((off - 1) / BAUD) : 1'b1;
    chk("busy", 32'(busy), 32'(e_busy));
    chk("done", 32'(done), 32'(e_done));
    chk("tx",   32'(tx),   32'(e_tx));
    if (done) done_cnt++;
    if (busy) busy_cnt++;
    if (!reset) begin
      if (mon_start < 0) begin
        if (tx == 1'b0 && prev_tx == 1'b1) mon_start = n;
      end else begin
        d = n - mon_start;
        if (d % BAUD == BAUD / 2) begin
          if (d / BAUD >= 1 && d / BAUD <= 8)
            mon_sh[d/BAUD - 1] = tx;
          if (d / BAUD == 9) begin
            chk("stop_bit", 32'(tx), 32'd1);
            rx_q.push_back(mon_sh);
            mon_start = -1;
          end
        end
      end
    end
    if (e_done) begin
      chk("nbytes", rx_q.size(), 32'd5);
      for (int i = 0; i < 5 && i < rx_q.size(); i++)
        chk($sformatf("byte%0d", i), 32'(rx_q[i]), 32'(m_bytes[i]));
      rx_q.delete();
    end
    prev_tx = tx;
  endtask

  task automatic pulse(input logic [31:0] d);
    send    = 1'b1;
    data_in = d;
    step();
    send    = 1'b0;
  endtask

  task automatic wait_done(input int limit,
                           input bit toggle,
                           input bit resend);
    int k;
    k = 0;
    while (!done && k < limit) begin
      if (toggle) data_in = $urandom;
      if (resend) send = ($urandom_range(0, 7) == 0);
      step();
      k++;
    end
    send = 1'b0;
    if (!done) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int acc;
    int done_n;
    int k;
    reset   = 1'b1;
    send    = 1'b0;
    data_in = '0;
    repeat (3) step();
    reset = 1'b0;
    repeat (50) step();

    // Frame with an ignored send halfway through
    busy_cnt = 0;
    done_cnt = 0;
    pulse(32'h1234_5678);
    acc = n;
    repeat (49) step();
    pulse(32'hFFFF_FFFF);
    wait_done(FRAME + 20, 1'b0, 1'b0);
    done_n = n;
    chk("done_at", 32'(done_n - acc), 32'(FRAME));
    chk("busy_len", 32'(busy_cnt), 32'(FRAME));
    chk("done_cnt1", 32'(done_cnt), 32'd1);

    // Back-to-back send in the done cycle
    busy_cnt = 0;
    done_cnt = 0;
    pulse(32'h0080_01FE);
    chk("b2b_busy", 32'(busy), 32'd1);
    step();
    chk("b2b_start", 32'(tx), 32'd0);
    wait_done(FRAME + 20, 1'b0, 1'b0);
    chk("done_cnt2", 32'(done_cnt), 32'd1);
    chk("busy_len2", 32'(busy_cnt), 32'(FRAME));

    // Reset inside the third byte
    repeat ($urandom_range(1, 5)) step();
    done_cnt = 0;
    pulse($urandom);
    acc = n;
    k = $urandom_range(81, 119);
    while (n < acc + k - 1) step();
    reset = 1'b1;
    step();
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    repeat (FRAME) step();
    chk("rst_no_done", 32'(done_cnt), 32'd0);
    pulse(32'hDEAD_BEEF);
    wait_done(FRAME + 20, 1'b0, 1'b0);

    // data_in scrambled every cycle while a frame is in flight
    repeat (3) step();
    pulse(32'hCAFE_0123);
    wait_done(FRAME + 20, 1'b1, 1'b0);

    // Random frames with stray send pulses and random gaps
    for (int r = 0; r < 6; r++) begin
      repeat ($urandom_range(0, 6)) step();
      done_cnt = 0;
      pulse($urandom);
      wait_done(FRAME + 20, 1'b1, 1'b1);
      chk("rand_done_cnt", 32'(done_cnt), 32'd1);
    end

    repeat (10) step();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
